// File: rtl/idu_issue_ctrl_if.sv
// Issue-controller bus: IF/ID request, scoreboard query/claim,
// ID/EX output handshake, flush and stall counter.
interface idu_issue_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_inst;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [4:0]       in_rd;
    logic             in_rs1_en;
    logic             in_rs2_en;
    logic             in_rd_en;

    logic             sb_valid;
    logic [4:0]       sb_raddr1;
    logic [4:0]       sb_raddr2;
    logic [4:0]       sb_waddr;
    logic             sb_wen;
    logic             sb_busy1;
    logic             sb_busy2;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_inst;
    logic [4:0]       out_rd;
    logic             out_rd_en;
    logic             out_squash;

    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, in_pc, in_inst,
        output in_rs1, in_rs2, in_rd,
        output in_rs1_en, in_rs2_en, in_rd_en,
        output sb_busy1, sb_busy2,
        output out_ready, flush,
        input  in_ready,
        input  sb_valid, sb_raddr1, sb_raddr2,
        input  sb_waddr, sb_wen,
        input  out_valid, out_pc, out_inst,
        input  out_rd, out_rd_en, out_squash,
        input  stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_inst,
        input  in_rs1, in_rs2, in_rd,
        input  in_rs1_en, in_rs2_en, in_rd_en,
        input  sb_busy1, sb_busy2,
        input  out_ready, flush,
        output in_ready,
        output sb_valid, sb_raddr1, sb_raddr2,
        output sb_waddr, sb_wen,
        output out_valid, out_pc, out_inst,
        output out_rd, out_rd_en, out_squash,
        output stall_cnt
    );
endinterface

// File: rtl/idu_issue_ctrl.sv
// Decode-stage issue control: RAW hazard hold, rd claim,
// one-entry ID/EX register with squash and hazard-stall counter.
module idu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input logic            clock,
    input logic            reset,
    idu_issue_ctrl_if.slave bus
);
    logic             hz1;
    logic             hz2;
    logic             hazard;
    logic             slot_free;
    logic             issue;
    logic             depart;

    logic             valid_q;
    logic             squash_q;
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      inst_q;
    logic [4:0]       rd_q;
    logic             rd_en_q;
    logic [CNT_W-1:0] cnt_q;

    // x0 is hardwired, so it can never be a pending write
    always_comb begin
        hz1       = bus.in_rs1_en & (bus.in_rs1 != 5'd0) & bus.sb_busy1;
        hz2       = bus.in_rs2_en & (bus.in_rs2 != 5'd0) & bus.sb_busy2;
        hazard    = bus.in_valid & (hz1 | hz2);
        slot_free = ~valid_q | bus.out_ready;
        issue     = bus.in_valid & ~hazard & slot_free & ~bus.flush;
        depart    = valid_q & bus.out_ready;
    end

    assign bus.in_ready   = issue;
    assign bus.sb_valid   = bus.in_valid;
    assign bus.sb_raddr1  = bus.in_rs1;
    assign bus.sb_raddr2  = bus.in_rs2;
    assign bus.sb_waddr   = bus.in_rd;
    assign bus.sb_wen     = issue & bus.in_rd_en & (bus.in_rd != 5'd0);

    assign bus.out_valid  = valid_q;
    assign bus.out_pc     = pc_q;
    assign bus.out_inst   = inst_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_rd_en  = rd_en_q;
    assign bus.out_squash = valid_q & (squash_q | bus.flush);
    assign bus.stall_cnt  = cnt_q;

    // squashed entries keep rd so writeback still frees the claim
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            squash_q <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            rd_q     <= '0;
            rd_en_q  <= 1'b0;
        end else if (issue) begin
            valid_q  <= 1'b1;
            squash_q <= 1'b0;
            pc_q     <= bus.in_pc;
            inst_q   <= bus.in_inst;
            rd_q     <= bus.in_rd;
            rd_en_q  <= bus.in_rd_en;
        end else if (depart) begin
            valid_q  <= 1'b0;
            squash_q <= 1'b0;
        end else if (bus.flush & valid_q) begin
            squash_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (hazard & ~bus.flush & (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Directed bench for idu_issue_ctrl with an expected-entry queue
// filled on accepted issues and drained on ID/EX departures.
module tb_idu_issue_ctrl;
    logic clock;
    logic reset;

    idu_issue_ctrl_if #(.XLEN(64), .CNT_W(32)) bus ();

    idu_issue_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_en;
        logic        sq;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(logic [63:0] pc, logic [4:0] rd, logic rd_en);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = 32'h0000_0013 | {20'd0, rd, 7'd0};
        bus.in_rd    = rd;
        bus.in_rd_en = rd_en;
    endtask

    // Inputs are set just after a negedge; check, then advance one cycle.
    task automatic step(string tag, logic exp_rdy, logic exp_wen);
        ent_t e;
        #1;
        chk({tag, ":in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
        chk({tag, ":sb_wen"}, 64'(bus.sb_wen), 64'(exp_wen));
        if (exp_wen)
            chk({tag, ":sb_waddr"}, 64'(bus.sb_waddr), 64'(bus.in_rd));
        chk({tag, ":out_valid"}, 64'(bus.out_valid),
            64'(q.size() != 0));
        if (bus.flush && q.size() != 0) q[0].sq = 1'b1;
        if (q.size() != 0)
            chk({tag, ":out_squash"}, 64'(bus.out_squash), 64'(q[0].sq));
        if (q.size() != 0 && bus.out_ready) begin
            e = q.pop_front();
            chk({tag, ":out_pc"}, bus.out_pc, e.pc);
            chk({tag, ":out_inst"}, 64'(bus.out_inst), 64'(e.inst));
            chk({tag, ":out_rd"}, 64'(bus.out_rd), 64'(e.rd));
            chk({tag, ":out_rd_en"}, 64'(bus.out_rd_en), 64'(e.rd_en));
        end
        if (exp_rdy) begin
            e.pc    = bus.in_pc;
            e.inst  = bus.in_inst;
            e.rd    = bus.in_rd;
            e.rd_en = bus.in_rd_en;
            e.sq    = 1'b0;
            q.push_back(e);
        end
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rd     = '0;
        bus.in_rs1_en = 1'b0;
        bus.in_rs2_en = 1'b0;
        bus.in_rd_en  = 1'b0;
        bus.sb_busy1  = 1'b0;
        bus.sb_busy2  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst:out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst:out_squash", 64'(bus.out_squash), 64'd0);
        chk("rst:out_pc", bus.out_pc, 64'd0);
        chk("rst:out_inst", 64'(bus.out_inst), 64'd0);
        chk("rst:out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst:out_rd_en", 64'(bus.out_rd_en), 64'd0);
        chk("rst:stall_cnt", 64'(bus.stall_cnt), 64'd0);
        @(negedge clock);

        // independent stream, full throughput
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_in(64'h1000 + 64'(4 * i), 5'(i), 1'b1);
            bus.in_rs1    = 5'(i + 10);
            bus.in_rs1_en = 1'b1;
            step("stream", 1'b1, 1'b1);
        end
        bus.in_valid = 1'b0;
        step("stream_drain", 1'b0, 1'b0);
        chk("stream:stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));

        // RAW hazard on rs1 for three cycles
        set_in(64'h2000, 5'd6, 1'b1);
        bus.in_rs1    = 5'd5;
        bus.in_rs1_en = 1'b1;
        bus.sb_busy1  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("raw_stall", 1'b0, 1'b0);
            exp_cnt++;
        end
        chk("raw:stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
        bus.sb_busy1 = 1'b0;
        step("raw_issue", 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        step("raw_drain", 1'b0, 1'b0);

        // x0 source and unused source never stall
        set_in(64'h3000, 5'd3, 1'b1);
        bus.in_rs1_en = 1'b0;
        bus.in_rs2    = 5'd0;
        bus.in_rs2_en = 1'b1;
        bus.sb_busy2  = 1'b1;
        step("x0_src", 1'b1, 1'b1);
        set_in(64'h3004, 5'd0, 1'b1);
        bus.in_rs2    = 5'd7;
        bus.in_rs2_en = 1'b0;
        step("unused_src_rd0", 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        bus.sb_busy2 = 1'b0;
        step("x0_drain", 1'b0, 1'b0);
        chk("x0:stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));

        // backpressure then same-edge swap
        bus.out_ready = 1'b0;
        set_in(64'h4000, 5'd8, 1'b1);
        step("bp_load", 1'b1, 1'b1);
        set_in(64'h4004, 5'd10, 1'b1);
        step("bp_hold", 1'b0, 1'b0);
        step("bp_hold", 1'b0, 1'b0);
        chk("bp:out_pc", bus.out_pc, 64'h4000);
        chk("bp:stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
        bus.out_ready = 1'b1;
        step("bp_swap", 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        step("bp_drain", 1'b0, 1'b0);

        // flush on a held entry, hazard during flush is not counted
        bus.out_ready = 1'b0;
        set_in(64'h5000, 5'd9, 1'b1);
        step("fl_load", 1'b1, 1'b1);
        set_in(64'h5004, 5'd4, 1'b1);
        bus.in_rs1    = 5'd5;
        bus.in_rs1_en = 1'b1;
        bus.sb_busy1  = 1'b1;
        bus.flush     = 1'b1;
        step("fl_flush", 1'b0, 1'b0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.sb_busy1 = 1'b0;
        step("fl_held", 1'b0, 1'b0);
        chk("fl:stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
        bus.out_ready = 1'b1;
        step("fl_leave", 1'b0, 1'b0);

        // entry leaving in the flush cycle carries squash
        set_in(64'h6000, 5'd11, 1'b1);
        step("fl2_load", 1'b1, 1'b1);
        set_in(64'h6004, 5'd12, 1'b1);
        bus.flush = 1'b1;
        step("fl2_leave", 1'b0, 1'b0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step("fl2_idle", 1'b0, 1'b0);

        // build stall_cnt to 12 with an entry held, then reset
        bus.out_ready = 1'b0;
        set_in(64'h7000, 5'd12, 1'b1);
        step("rs_load", 1'b1, 1'b1);
        set_in(64'h7004, 5'd13, 1'b1);
        bus.in_rs1    = 5'd12;
        bus.in_rs1_en = 1'b1;
        bus.sb_busy1  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step("rs_stall", 1'b0, 1'b0);
            exp_cnt++;
        end
        chk("rs:stall_cnt_pre", 64'(bus.stall_cnt), 64'd12);
        chk("rs:out_valid_pre", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rs:out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs:out_squash", 64'(bus.out_squash), 64'd0);
        chk("rs:stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rs:out_rd_en", 64'(bus.out_rd_en), 64'd0);
        q.delete();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.sb_busy1 = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/idu_issue_ctrl.md
Name: idu_issue_ctrl

Overview:
- Decode-stage issue controller between the IF/ID register and the EXU input.
- Queries the register scoreboard for RAW hazards on rs1/rs2 and holds the instruction while a source is busy.
- On issue, it claims rd in the scoreboard and loads a one-entry ID/EX output register with a valid/ready handshake.
- It supports branch-redirect squash and keeps a hazard-stall performance counter.

Parameters:
- XLEN, 64, width of the PC datapath.
- CNT_W, 32, width of the stall counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  32  raw instruction.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_rs1_en, in_rs2_en, in_rd_en  in  1 each  source-used and dest-written flags.
- sb_valid  out  1  scoreboard query valid (= in_valid).
- sb_raddr1, sb_raddr2  out  5 each  = in_rs1, in_rs2.
- sb_waddr  out  5  = in_rd.
- sb_wen  out  1  claim rd busy.
- sb_busy1, sb_busy2  in  1 each  scoreboard busy for rs1, rs2.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  EXU accepts the entry.
- out_pc  out  XLEN  registered PC.
- out_inst  out  32  registered instruction.
- out_rd  out  5  registered rd.
- out_rd_en  out  1  registered rd write flag.
- out_squash  out  1  entry is squashed: treat as NOP, but still release rd at WBU.
- flush  in  1  branch redirect from EXU.
- stall_cnt  out  CNT_W  cycles stalled on a RAW hazard.

Behaviour:
- Reset (synchronous): out_valid=0, squash_q=0, stall_cnt=0, out_pc/out_inst/out_rd=0, out_rd_en=0.
- hazard = in_valid & ((in_rs1_en & (in_rs1!=0) & sb_busy1) | (in_rs2_en & (in_rs2!=0) & sb_busy2)). Combinational.
- slot_free = !out_valid | out_ready.
- issue = in_valid & !hazard & slot_free & !flush. in_ready = issue.
- sb_wen = issue & in_rd_en & (in_rd!=0). It is asserted only in the issue cycle, never while stalled.
- Output register, on a clock edge:
  - if issue: load pc/inst/rd/rd_en, out_valid<=1, squash_q<=0.
  - else if out_valid & out_ready: out_valid<=0, squash_q<=0.
  - else if flush & out_valid: squash_q<=1; the entry is held.
- out_squash = out_valid & (squash_q | flush). An entry leaving during the flush cycle therefore carries squash=1.
- Squashed entries keep out_rd/out_rd_en so WBU clears the scoreboard bit. No busy bit is ever left stuck.
- Issue latency: accepted at edge N, out_valid=1 from N+1. Back-to-back issue is allowed when out_ready=1 every cycle (full throughput).
- Back-to-back dependent instructions: the consumer stalls (in_ready=0) until sb_busy clears through WBU. There is no bypass in this block.
- Source index x0 is never a hazard, even if sb_busy were 1.
- Flush cycle: no issue and no sb_wen. The IF/ID entry is discarded upstream. in_valid the following cycle is a new-path instruction.
- stall_cnt increments by 1 on each edge where in_valid & hazard & !flush. It saturates at all-ones. It does not count structural stalls (slot_free=0).
- Simultaneous issue and out_ready: the old entry departs and the new entry loads on the same edge.
- Reset mid-operation: all state clears the next edge regardless of flush/handshake. Scoreboard reset is handled by the scoreboard itself.

Test Plan:
- Independent stream: in_valid=1, no busy, out_ready=1, 4 instr rd=1..4 -> in_ready=1 each cycle; sb_wen pulses with waddr 1,2,3,4; out_valid=1 from cycle 1 with matching PCs; stall_cnt=0.
- RAW stall: sb_busy1=1 for 3 cycles, in_rs1=5, in_rs1_en=1 -> in_ready=0, sb_wen=0 for 3 cycles, stall_cnt=3; issues on the 4th cycle.
- x0 and unused source: in_rs2=0, sb_busy2=1; then in_rs2=7, in_rs2_en=0, sb_busy2=1 -> no stall, immediate issue both cases.
- Backpressure: out_ready=0 with out_valid=1, next in_valid with no hazard -> in_ready=0, output holds, stall_cnt unchanged; out_ready=1 -> swap on the same edge.
- Flush: out_valid=1, out_rd=9, out_ready=0, flush=1 -> out_squash=1 immediately and stays 1; no issue that cycle; on later out_ready=1 the entry leaves with out_rd=9, out_rd_en=1, squash=1.
- Reset mid-stream: reset=1 while out_valid=1 and stall_cnt=12 -> next edge out_valid=0, out_squash=0, stall_cnt=0.
